// File: rtl/trie_sched_pkg.sv
// Shared types and constants for the trie lookup front-end and the trie pipeline top.
package trie_sched_pkg;

    localparam int unsigned LOOKUP_LAT_DFLT = 9;
    localparam int unsigned NH_W            = 8;
    localparam int unsigned IP_W            = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/trie_lookup_scheduler_rr_arbiter.sv
// Round-robin one-hot arbiter; the priority pointer is owned by the caller.
module trie_rr_arbiter
    import trie_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant
);

    localparam int unsigned SW = ID_W + 1;

    logic [SW-1:0] w_idx;
    logic          w_found;

    // Scan ports starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int off = 0; off < int'(NUM_REQ); off++) begin
            w_idx = {1'b0, i_ptr} + SW'(off);
            if (w_idx >= SW'(NUM_REQ)) begin
                w_idx = w_idx - SW'(NUM_REQ);
            end
            if (i_en && !w_found && i_req[w_idx[ID_W-1:0]]) begin
                o_grant[w_idx[ID_W-1:0]] = 1'b1;
                w_found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trie_lookup_scheduler.sv
// Shares the trie pipeline among NUM_REQ requesters, tags results with the
// requester ID, and drains the pipeline before handing the RAMs to the updater.
module trie_lookup_scheduler
    import trie_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = $clog2(NUM_REQ),
    parameter int unsigned LOOKUP_LAT = LOOKUP_LAT_DFLT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [NUM_REQ*IP_W-1:0] i_req_ip,
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic                    o_pipe_valid,
    output logic [IP_W-1:0]         o_pipe_ip,
    input  logic [NH_W-1:0]         i_pipe_nexthop,
    output logic                    o_rsp_valid,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [NH_W-1:0]         o_rsp_nexthop,
    input  logic                    i_upd_req,
    output logic                    o_upd_gnt,
    output logic                    o_busy
);

    localparam int unsigned CNT_W = $clog2(LOOKUP_LAT + 2);
    localparam int unsigned DL_N  = LOOKUP_LAT + 1;

    sched_state_e                r_state;
    sched_state_e                w_state_nxt;
    logic [ID_W-1:0]             r_ptr;
    logic [CNT_W-1:0]            r_cnt;
    logic [DL_N-1:0]             r_tag_vld;
    logic [DL_N-1:0][ID_W-1:0]   r_tag_id;

    logic                        w_arb_en;
    logic [NUM_REQ-1:0]          w_grant;
    logic                        w_accept;
    logic                        w_rsp;
    logic [ID_W-1:0]             w_gnt_id;
    logic [IP_W-1:0]             w_gnt_ip;
    logic [ID_W-1:0]             w_ptr_nxt;

    trie_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_arb_en),
        .o_grant (w_grant)
    );

    assign o_req_ready = w_grant;
    assign w_accept    = |w_grant;
    assign w_rsp       = r_tag_vld[DL_N-1];
    assign o_busy      = (r_cnt != '0);
    assign w_ptr_nxt   = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

    // Encode the one-hot grant and select the winning address.
    always_comb begin
        w_gnt_id = '0;
        w_gnt_ip = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_grant[i]) begin
                w_gnt_id = ID_W'(i);
                w_gnt_ip = i_req_ip[IP_W*i +: IP_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Requests are only granted in RUN with no pending update; the update always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_arb_en    = 1'b0;
        unique case (r_state)
            RUN: begin
                w_arb_en = rst && !i_upd_req;
                if (i_upd_req) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!i_upd_req) begin
                    w_state_nxt = RUN;
                end else if (r_cnt == '0) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!i_upd_req) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr        <= '0;
            o_pipe_valid <= 1'b0;
            o_pipe_ip    <= '0;
            o_upd_gnt    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ptr <= w_ptr_nxt;
            end
            o_pipe_valid <= w_accept;
            o_pipe_ip    <= w_accept ? w_gnt_ip : '0;
            o_upd_gnt    <= (w_state_nxt == HOLD);
        end
    end

    // Tag delay line: the tail lines up with the pipeline result of the same lookup.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tag_vld     <= '0;
            r_tag_id      <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_id      <= '0;
            o_rsp_nexthop <= '0;
        end else begin
            r_tag_vld     <= {r_tag_vld[DL_N-2:0], w_accept};
            r_tag_id      <= {r_tag_id[DL_N-2:0], w_gnt_id};
            o_rsp_valid   <= w_rsp;
            o_rsp_id      <= w_rsp ? r_tag_id[DL_N-1] : '0;
            o_rsp_nexthop <= w_rsp ? i_pipe_nexthop : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            unique case ({w_accept, w_rsp})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_trie_lookup_scheduler.sv
// Directed bench for trie_lookup_scheduler with a stub trie pipeline and a
// scoreboard of expected tagged results.
module tb_trie_lookup_scheduler;
    import trie_sched_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned LAT  = 9;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     nh;
        logic [31:0]    edge_no;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*32-1:0]   req_ip = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 pipe_valid;
    logic [31:0]          pipe_ip;
    logic [7:0]           pipe_nexthop;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [7:0]           rsp_nexthop;
    logic                 upd_req = 1'b0;
    logic                 upd_gnt;
    logic                 busy;

    int                   n_pass = 0;
    int                   n_chk  = 0;
    logic [31:0]          edge_cnt = '0;
    int                   m_ptr = 0;
    exp_t                 sb[$];

    always #5 clk = ~clk;

    trie_lookup_scheduler #(
        .NUM_REQ    (NREQ),
        .ID_W       (IDW),
        .LOOKUP_LAT (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (req_valid),
        .i_req_ip       (req_ip),
        .o_req_ready    (req_ready),
        .o_pipe_valid   (pipe_valid),
        .o_pipe_ip      (pipe_ip),
        .i_pipe_nexthop (pipe_nexthop),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_id       (rsp_id),
        .o_rsp_nexthop  (rsp_nexthop),
        .i_upd_req      (upd_req),
        .o_upd_gnt      (upd_gnt),
        .o_busy         (busy)
    );

    function automatic logic [7:0] nh_of(input logic [31:0] ip);
        return ip[7:0] + ip[15:8] + 8'd6;
    endfunction

    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int p, output int gi);
        int j;
        rr_pick = '0;
        gi      = -1;
        for (int k = 0; k < int'(NREQ); k++) begin
            j = (p + k) % int'(NREQ);
            if (v[j] && gi < 0) begin
                gi         = j;
                rr_pick[j] = 1'b1;
            end
        end
    endfunction

    // Stub trie pipeline: result appears LAT edges after launch, garbage otherwise.
    logic [LAT-1:0]        stg_v  = '0;
    logic [LAT-1:0][31:0]  stg_ip = '0;
    always @(posedge clk) begin
        stg_v    <= {stg_v[LAT-2:0], pipe_valid};
        stg_ip   <= {stg_ip[LAT-2:0], pipe_ip};
        edge_cnt <= edge_cnt + 32'd1;
    end
    assign pipe_nexthop = stg_v[LAT-1] ? nh_of(stg_ip[LAT-1]) : 8'hEE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accept with an independent round-robin model, pop on result.
    always @(negedge clk) begin : mon
        logic [NREQ-1:0] g;
        int              gi;
        exp_t            e;
        if (!rst) begin
            m_ptr = 0;
        end else begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_nexthop", 32'(rsp_nexthop), 32'(e.nh));
                    chk("rsp_latency", edge_cnt, e.edge_no + LAT + 1);
                end
            end
            if (upd_req) begin
                chk("ready_gated_by_upd", 32'(req_ready), 32'd0);
            end
            if (req_ready != '0) begin
                g = rr_pick(req_valid, m_ptr, gi);
                chk("rr_grant", 32'(req_ready), 32'(g));
                if (gi >= 0) begin
                    e.id      = IDW'(gi);
                    e.nh      = nh_of(req_ip[32*gi +: 32]);
                    e.edge_no = edge_cnt + 32'd1;
                    sb.push_back(e);
                    m_ptr = (gi + 1) % int'(NREQ);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < int'(4 * LAT)) begin
            tick();
            n++;
        end
        chk("idle_sb_empty", 32'(sb.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero();
        chk("zero_req_ready", 32'(req_ready), 32'd0);
        chk("zero_pipe_valid", 32'(pipe_valid), 32'd0);
        chk("zero_pipe_ip", pipe_ip, 32'd0);
        chk("zero_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("zero_rsp_id", 32'(rsp_id), 32'd0);
        chk("zero_rsp_nexthop", 32'(rsp_nexthop), 32'd0);
        chk("zero_upd_gnt", 32'(upd_gnt), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   n;
        int   seen;
        logic prev_busy;
        logic [NREQ-1:0] sparse_exp [3];

        // Reset: requests held valid must not be granted.
        rst       = 1'b0;
        req_valid = '1;
        repeat (3) tick();
        chk_all_zero();
        req_valid = '0;
        rst       = 1'b1;

        // Fairness: all ports valid for 8 cycles.
        for (int p = 0; p < int'(NREQ); p++) begin
            req_ip[32*p +: 32] = {8'd10, 8'(p), 8'd0, 8'(16 * p + 1)};
        end
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fair_grant", 32'(req_ready), 32'(1 << (i % 4)));
            tick();
        end
        req_valid = '0;
        wait_idle();

        // Single lookup on port 2 with exact latency.
        req_ip[64 +: 32] = 32'h0A000001;
        req_valid        = 4'b0100;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk("single_pipe_valid", 32'(pipe_valid), 32'd1);
        chk("single_pipe_ip", pipe_ip, 32'h0A000001);
        tick();
        chk("single_pipe_valid_drop", 32'(pipe_valid), 32'd0);
        chk("single_pipe_ip_drop", pipe_ip, 32'd0);
        repeat (LAT - 1) tick();
        chk("single_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_id", 32'(rsp_id), 32'd2);
        chk("single_rsp_nh", 32'(rsp_nexthop), 32'd7);
        tick();
        chk("single_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        wait_idle();

        // Sparse round-robin: move pointer to 1, then only ports 0 and 3 valid.
        req_valid = 4'b0001;
        @(negedge clk);
        chk("sparse_setup", 32'(req_ready), 32'h1);
        tick();
        sparse_exp[0] = 4'b1000;
        sparse_exp[1] = 4'b0001;
        sparse_exp[2] = 4'b1000;
        req_valid     = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sparse_grant", 32'(req_ready), 32'(sparse_exp[i]));
            tick();
        end
        req_valid = '0;
        wait_idle();

        // Drain with 5 lookups in flight.
        req_valid = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            chk("drain_fill", 32'(req_ready), 32'h2);
            tick();
        end
        upd_req   = 1'b1;
        n         = 0;
        prev_busy = 1'b1;
        while (!upd_gnt && n < int'(3 * LAT)) begin
            @(negedge clk);
            chk("drain_ready_gated", 32'(req_ready), 32'd0);
            prev_busy = busy;
            tick();
            n++;
        end
        chk("drain_gnt_edges", 32'(n), 32'(LAT + 2));
        chk("drain_idle_before_gnt", 32'(prev_busy), 32'd0);
        chk("drain_all_delivered", 32'(sb.size()), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("hold_gnt", 32'(upd_gnt), 32'd1);
            chk("hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        upd_req = 1'b0;
        @(negedge clk);
        chk("release_ready", 32'(req_ready), 32'd0);
        tick();
        chk("release_gnt_drop", 32'(upd_gnt), 32'd0);
        @(negedge clk);
        chk("resume_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        wait_idle();

        // Abort: update request withdrawn while lookups are still in flight.
        req_valid = 4'b0100;
        repeat (3) begin
            @(negedge clk);
            chk("abort_fill", 32'(req_ready), 32'h4);
            tick();
        end
        req_valid = 4'b0001;
        upd_req   = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_ready", 32'(req_ready), 32'd0);
            chk("abort_no_gnt", 32'(upd_gnt), 32'd0);
            tick();
        end
        upd_req = 1'b0;
        @(negedge clk);
        chk("abort_drain_ready", 32'(req_ready), 32'd0);
        chk("abort_no_gnt", 32'(upd_gnt), 32'd0);
        tick();
        @(negedge clk);
        chk("abort_resume", 32'(req_ready), 32'h1);
        chk("abort_no_gnt", 32'(upd_gnt), 32'd0);
        tick();
        req_valid = '0;
        wait_idle();
        chk("abort_gnt_final", 32'(upd_gnt), 32'd0);

        // Reset with 3 lookups in flight: nothing comes back.
        req_valid = 4'b1000;
        repeat (3) begin
            @(negedge clk);
            chk("rst_fill", 32'(req_ready), 32'h8);
            tick();
        end
        req_valid = '0;
        rst       = 1'b0;
        tick();
        chk_all_zero();
        sb.delete();
        rst  = 1'b1;
        seen = 0;
        repeat (2 * LAT) begin
            @(negedge clk);
            if (rsp_valid) seen++;
            tick();
        end
        chk("rst_no_stale_rsp", 32'(seen), 32'd0);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("rst_ptr_restart", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
